// File: rtl/paramul.sv
// Shared definitions for the 3x3 matrix-vector engine: FSM encoding and
// matrix geometry constants.
package paramul;

  localparam int unsigned MAT_DIM = 3;
  localparam int unsigned N_ELEM  = MAT_DIM * MAT_DIM;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/mat_vec_engine_if.sv
// Command, BRAM read port and result handshake of the matrix-vector engine.
// master = environment (issues commands, models BRAM, consumes results),
// slave  = the engine itself.
interface mat_vec_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) ();

  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [3*DATA_W-1:0]   vec_in;
  logic                  r_en;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  busy;
  logic [2*DATA_W-1:0]   y_data;
  logic [1:0]            y_idx;
  logic                  y_valid;
  logic                  y_ready;
  logic                  done;

  modport master (
    output start, base_addr, vec_in, r_data, y_ready,
    input  r_en, r_addr, busy, y_data, y_idx, y_valid, done
  );

  modport slave (
    input  start, base_addr, vec_in, r_data, y_ready,
    output r_en, r_addr, busy, y_data, y_idx, y_valid, done
  );

endinterface

// File: rtl/mac_unit.sv
// Multiply-accumulate datapath: sign-extends a matrix word and a vector
// element to 2*DATA_W, multiplies and adds into the selected row
// accumulator. All arithmetic wraps at 2*DATA_W bits.
module mac_unit
  import paramul::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear_i,
  input  logic                              en_i,
  input  logic [1:0]                        row_i,
  input  logic [DATA_W-1:0]                 m_i,
  input  logic [DATA_W-1:0]                 x_i,
  output logic [MAT_DIM-1:0][2*DATA_W-1:0]  acc_o
);

  localparam int AW = 2 * DATA_W;

  logic signed [AW-1:0]        m_ext;
  logic signed [AW-1:0]        x_ext;
  logic signed [AW-1:0]        prod;
  logic [MAT_DIM-1:0][AW-1:0]  acc_q;
  logic [MAT_DIM-1:0][AW-1:0]  acc_d;

  assign m_ext = {{DATA_W{m_i[DATA_W-1]}}, m_i};
  assign x_ext = {{DATA_W{x_i[DATA_W-1]}}, x_i};
  assign prod  = m_ext * x_ext;

  // Next accumulator values: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      for (int r = 0; r < MAT_DIM; r++) begin
        if (row_i == 2'(r)) acc_d[r] = acc_q[r] + prod;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mat_vec_engine.sv
// 3x3 matrix x vector engine. Streams nine row-major matrix words out of a
// BRAM, accumulates each row against the latched vector, then hands the
// three row results out over a valid/ready port.
//
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issuing the nine BRAM reads (r_en high)
//   DRAIN | reads done, waiting for the last word to return
//   OUT   | presenting rows 0..2; accepting row 2 finishes (done pulse)
module mat_vec_engine
  import paramul::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  mat_vec_engine_if.slave    bus
);

  localparam logic [3:0] LAST_K   = 4'(N_ELEM - 1);
  localparam logic [1:0] LAST_IDX = 2'(MAT_DIM - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [3*DATA_W-1:0]   vec_q, vec_d;
  logic [3:0]            k_q, k_d;
  logic [1:0]            row_q, row_d;
  logic [1:0]            col_q, col_d;
  logic [1:0]            out_q, out_d;
  logic [RD_LAT-1:0]     rd_pipe_q, rd_pipe_d;

  logic                  fetch;
  logic                  word_vld;
  logic                  last_word;
  logic                  accept;
  logic                  done_w;
  logic                  launch;
  logic [DATA_W-1:0]     x_sel;
  logic [2*DATA_W-1:0]   y_data_w;
  logic [MAT_DIM-1:0][2*DATA_W-1:0] acc;

  assign fetch     = (state_q == ST_FETCH);
  assign word_vld  = rd_pipe_q[RD_LAT-1];
  assign last_word = word_vld && (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign accept    = (state_q == ST_OUT) && bus.y_ready;
  assign done_w    = accept && (out_q == LAST_IDX);
  // A start coinciding with the final accept is taken, so back-to-back
  // operations lose no cycle.
  assign launch    = bus.start && ((state_q == ST_IDLE) || done_w);

  // Read-valid pipeline: marks which cycles carry a requested BRAM word.
  always_comb begin
    rd_pipe_d    = rd_pipe_q;
    rd_pipe_d[0] = fetch;
    for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  // Vector element for the column of the word currently returning.
  always_comb begin
    x_sel = vec_q[DATA_W-1:0];
    case (col_q)
      2'd1:    x_sel = vec_q[2*DATA_W-1:DATA_W];
      2'd2:    x_sel = vec_q[3*DATA_W-1:2*DATA_W];
      default: x_sel = vec_q[DATA_W-1:0];
    endcase
  end

  // Next-state, operand latch and row/column/address counter logic.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    vec_d   = vec_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    out_d   = out_q;

    if (word_vld) begin
      if (col_q == LAST_IDX) begin
        col_d = 2'd0;
        row_d = row_q + 2'd1;
      end else begin
        col_d = col_q + 2'd1;
      end
    end

    case (state_q)
      ST_IDLE: ;
      ST_FETCH: begin
        k_d = k_q + 4'd1;
        if (k_q == LAST_K) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_word) begin
          state_d = ST_OUT;
          out_d   = 2'd0;
        end
      end
      ST_OUT: begin
        if (accept) begin
          if (out_q == LAST_IDX) state_d = ST_IDLE;
          else                   out_d   = out_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_FETCH;
      base_d  = bus.base_addr;
      vec_d   = bus.vec_in;
      k_d     = 4'd0;
      row_d   = 2'd0;
      col_d   = 2'd0;
      out_d   = 2'd0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      vec_q     <= '0;
      k_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      out_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      vec_q     <= vec_d;
      k_q       <= k_d;
      row_q     <= row_d;
      col_q     <= col_d;
      out_q     <= out_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  mac_unit #(
    .DATA_W (DATA_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (launch),
    .en_i    (word_vld),
    .row_i   (row_q),
    .m_i     (bus.r_data),
    .x_i     (x_sel),
    .acc_o   (acc)
  );

  // Result mux: row selected by the output index.
  always_comb begin
    y_data_w = acc[0];
    case (out_q)
      2'd1:    y_data_w = acc[1];
      2'd2:    y_data_w = acc[2];
      default: y_data_w = acc[0];
    endcase
  end

  assign bus.r_en    = fetch;
  assign bus.r_addr  = fetch ? (base_q + ADDR_W'(k_q)) : '0;
  assign bus.busy    = (state_q != ST_IDLE) && !done_w;
  assign bus.y_valid = (state_q == ST_OUT);
  assign bus.y_idx   = out_q;
  assign bus.y_data  = y_data_w;
  assign bus.done    = done_w;

endmodule
